// File: rtl/cpu_test_harness_loader.sv
// Sequencer placed upstream of the pipelined cpu top. It loads a program image into
// instruction memory and an initial image into data memory from a valid/ready word stream,
// runs the cpu for a programmed number of cycles, then streams a data-memory window back out.
//
// Ports:
//   clk, arst_n                 clock, asynchronous active-low reset
//   start + *_words/run_cycles  sequence launch pulse and phase counts (latched on start)
//   in_valid/in_data/in_ready   load stream (instruction words first, then data words)
//   out_valid/out_data/out_ready dump stream
//   *_ext                       instruction-memory external port (write only)
//   *_ext_2, rdata_ext_2        data-memory external port (write on load, read on dump)
//   enable                      cpu execution enable
//   busy, done                  sequence status
module cpu_test_harness_loader #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned DUMP_BASE = 0
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] imem_words,
  input  logic [CNT_W-1:0] dmem_words,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] dump_words,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready,
  output logic [31:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  output logic [31:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [31:0]      wdata_ext_2,
  input  logic [31:0]      rdata_ext_2,
  output logic             enable,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadI,
    StLoadD,
    StRun,
    StDumpReq,
    StDumpLat,
    StDumpOut,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] imem_q, imem_d;
  logic [CNT_W-1:0] dmem_q, dmem_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] dump_q, dump_d;
  logic [31:0]      out_data_q, out_data_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [31:0]      cnt_addr;
  state_e           first_phase, after_i, after_d, after_run;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign cnt_addr = 32'(cnt_q) * ADDR_STEP;

  // Phase skipping: each phase hands over to the next one whose count is nonzero.
  // The start decision looks at the live inputs since they are being latched that cycle.
  assign after_run   = (dump_q != '0) ? StDumpReq : StDone;
  assign after_d     = (run_q != '0) ? StRun : after_run;
  assign after_i     = (dmem_q != '0) ? StLoadD : after_d;
  assign first_phase = (imem_words != '0) ? StLoadI :
                       (dmem_words != '0) ? StLoadD :
                       (run_cycles != '0) ? StRun :
                       (dump_words != '0) ? StDumpReq : StDone;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    imem_d      = imem_q;
    dmem_d      = dmem_q;
    run_d       = run_q;
    dump_d      = dump_q;
    out_data_d  = out_data_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    addr_ext    = 32'h0;
    wen_ext     = 1'b0;
    wdata_ext   = 32'h0;
    addr_ext_2  = 32'h0;
    wen_ext_2   = 1'b0;
    ren_ext_2   = 1'b0;
    wdata_ext_2 = 32'h0;
    enable      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          imem_d  = imem_words;
          dmem_d  = dmem_words;
          run_d   = run_cycles;
          dump_d  = dump_words;
          cnt_d   = '0;
          state_d = first_phase;
        end
      end
      StLoadI: begin
        in_ready = 1'b1;
        addr_ext = cnt_addr;
        if (in_valid) begin
          wen_ext   = 1'b1;
          wdata_ext = in_data;
          if (cnt_inc == imem_q) begin
            cnt_d   = '0;
            state_d = after_i;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StLoadD: begin
        in_ready   = 1'b1;
        addr_ext_2 = cnt_addr;
        if (in_valid) begin
          wen_ext_2   = 1'b1;
          wdata_ext_2 = in_data;
          if (cnt_inc == dmem_q) begin
            cnt_d   = '0;
            state_d = after_d;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      StRun: begin
        enable = 1'b1;
        if (cnt_inc == run_q) begin
          cnt_d   = '0;
          state_d = after_run;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDumpReq: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = DUMP_BASE + cnt_addr;
        state_d    = StDumpLat;
      end
      StDumpLat: begin
        // Read data returns one cycle after the request; capture it here.
        out_data_d = rdata_ext_2;
        state_d    = StDumpOut;
      end
      StDumpOut: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (cnt_inc == dump_q) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d   = cnt_inc;
            state_d = StDumpReq;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ren_ext  = 1'b0;
  assign out_data = out_data_q;
  assign busy     = (state_q != StIdle) && (state_q != StDone);
  assign done     = (state_q == StDone);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      imem_q     <= '0;
      dmem_q     <= '0;
      run_q      <= '0;
      dump_q     <= '0;
      out_data_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      imem_q     <= imem_d;
      dmem_q     <= dmem_d;
      run_q      <= run_d;
      dump_q     <= dump_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_cpu_test_harness_loader.sv
// Bench for cpu_test_harness_loader: memories, a tiny stand-in cpu and a stream driver live
// here; expected contents and dump streams come from the word lists each test generates.
module tb_cpu_test_harness_loader;
  localparam int unsigned CntW = 16;

  logic            clk = 1'b0;
  logic            arst_n = 1'b0;
  logic            start = 1'b0;
  logic [CntW-1:0] imem_words = '0, dmem_words = '0, run_cycles = '0, dump_words = '0;
  logic            in_valid = 1'b0;
  logic [31:0]     in_data = 32'h0;
  logic            in_ready, out_valid;
  logic [31:0]     out_data;
  logic            out_ready = 1'b0;
  logic [31:0]     addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
  logic [31:0]     rdata_ext_2 = 32'h0;
  logic            wen_ext, ren_ext, wen_ext_2, ren_ext_2, enable, busy, done;

  always #5 clk = ~clk;

  cpu_test_harness_loader #(.CNT_W(CntW), .ADDR_STEP(4), .DUMP_BASE(0)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .imem_words(imem_words), .dmem_words(dmem_words),
    .run_cycles(run_cycles), .dump_words(dump_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .enable(enable), .busy(busy), .done(done)
  );

  logic [168:0] all_out;
  assign all_out = {in_ready, out_valid, out_data, addr_ext, wen_ext, ren_ext, wdata_ext,
                    addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2, enable, busy, done};

  // Memories, port monitor and a stand-in cpu that knows addi/add/sw only.
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] regs [32];
  logic [7:0]  pc = 8'h0;
  logic        cpu_rst = 1'b0, cpu_on = 1'b0;
  int          cpu_len = 0;
  int          en_cycles = 0, tie_err = 0;
  int unsigned imem_wa[$], dmem_wa[$], ren_a[$];
  logic [31:0] ci, simm, sw_addr;
  assign ci      = imem[pc];
  assign simm    = {{16{ci[15]}}, ci[15:0]};
  assign sw_addr = regs[ci[25:21]] + simm;

  always @(posedge clk) begin
    if (wen_ext) begin
      imem[addr_ext[9:2]] <= wdata_ext;
      imem_wa.push_back(addr_ext);
    end
    if (wen_ext_2) begin
      dmem[addr_ext_2[9:2]] <= wdata_ext_2;
      dmem_wa.push_back(addr_ext_2);
    end
    if (ren_ext_2) ren_a.push_back(addr_ext_2);
    rdata_ext_2 <= ren_ext_2 ? dmem[addr_ext_2[9:2]] : 32'h0;
    if (enable) en_cycles <= en_cycles + 1;
    if (ren_ext || (wen_ext && wen_ext_2) || (enable && (wen_ext || wen_ext_2)) ||
        ((wen_ext || wen_ext_2) && !in_valid))
      tie_err <= tie_err + 1;
    if (cpu_rst) begin
      pc <= 8'h0;
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (enable && cpu_on && int'(pc) < cpu_len) begin
      pc <= pc + 8'h1;
      if (ci[31:26] == 6'h08 && ci[20:16] != 5'd0)
        regs[ci[20:16]] <= regs[ci[25:21]] + simm;
      else if (ci[31:26] == 6'h00 && ci[5:0] == 6'h20 && ci[15:11] != 5'd0)
        regs[ci[15:11]] <= regs[ci[25:21]] + regs[ci[20:16]];
      else if (ci[31:26] == 6'h2B)
        dmem[sw_addr[9:2]] <= regs[ci[20:16]];
    end
  end

  int          n_tests = 0, n_fail = 0;
  logic [31:0] words[$];
  logic [31:0] got[$];
  int          stab_err = 0, stall_cycles = 0;

  task automatic do_start(input int i, input int d, input int r, input int u);
    @(negedge clk);
    imem_words = CntW'(i);
    dmem_words = CntW'(d);
    run_cycles = CntW'(r);
    dump_words = CntW'(u);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // vmode: 0 always valid, 1 random, 2 alternating. rmode: 0 always ready, 1 random.
  task automatic session(input int vmode, input int rmode, input int hold_first, input bit poke);
    int idx = 0;
    int hold_left = hold_first;
    bit held = 1'b0, poked = 1'b0, finished = 1'b0;
    logic [31:0] held_data = 32'h0;
    got.delete();
    stab_err = 0;
    stall_cycles = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (held && (!out_valid || out_data !== held_data)) stab_err++;
      in_valid = (idx < words.size()) &&
                 (vmode == 0 || (vmode == 1 && $urandom_range(1) == 1) ||
                  (vmode == 2 && c % 2 == 0));
      in_data = in_valid ? words[idx] : $urandom;
      if (out_valid && hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = (rmode == 0) || ($urandom_range(1) == 1);
      end
      if (poke && enable && !poked) begin
        poked = 1'b1;
        start = 1'b1;
        imem_words = CntW'(5);
        dump_words = CntW'(7);
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        held = 1'b0;
      end else if (out_valid) begin
        held = 1'b1;
        held_data = out_data;
        stall_cycles++;
      end else begin
        held = 1'b0;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (!finished) begin
      n_fail++;
      $display("FAIL session_timeout: done=%0b required 1", done);
    end
  endtask

  task automatic test_reset;
    int acc = 0;
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", all_out);
    end
    words = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003, 32'h1111_0004};
    do_start(4, 0, 0, 0);
    for (int c = 0; c < 20 && acc < 2; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data = words[acc];
      if (in_ready) acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if ({busy, in_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_mid_load_state: busy,in_ready=%b required 11", {busy, in_ready});
    end
    #2 arst_n = 1'b0;
    #1;
    n_tests++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_async_outputs: got %h required 0", all_out);
    end
    n_tests++;
    if (imem[0] !== 32'h1111_0001 || imem[1] !== 32'h1111_0002) begin
      n_fail++;
      $display("FAIL reset_partial_kept: imem0=%h imem1=%h required 11110001 11110002",
               imem[0], imem[1]);
    end
    @(negedge clk);
    arst_n = 1'b1;
    words = '{32'h1234_5678};
    do_start(1, 0, 0, 0);
    session(0, 0, 0, 1'b0);
    n_tests++;
    if (imem[0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL reset_restart: imem0=%h required 12345678", imem[0]);
    end
  endtask

  task automatic test_load;
    int ib = imem_wa.size(), db = dmem_wa.size();
    logic [31:0] exp_w [5];
    exp_w = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'h11, 32'h22};
    words = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'h11, 32'h22};
    do_start(3, 2, 0, 0);
    session(0, 0, 0, 1'b0);
    n_tests++;
    if (imem_wa.size() - ib != 3 || dmem_wa.size() - db != 2) begin
      n_fail++;
      $display("FAIL load_write_counts: imem=%0d dmem=%0d required 3 2",
               imem_wa.size() - ib, dmem_wa.size() - db);
    end else begin
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (imem_wa[ib+k] != 32'(4 * k) || imem[k] !== exp_w[k]) begin
          n_fail++;
          $display("FAIL load_imem[%0d]: addr=%0d data=%h required %0d %h", k, imem_wa[ib+k],
                   imem[k], 4 * k, exp_w[k]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (dmem_wa[db+k] != 32'(4 * k) || dmem[k] !== exp_w[3+k]) begin
          n_fail++;
          $display("FAIL load_dmem[%0d]: addr=%0d data=%h required %0d %h", k, dmem_wa[db+k],
                   dmem[k], 4 * k, exp_w[3+k]);
        end
      end
    end
  endtask

  task automatic test_backpressure;
    int ib = imem_wa.size();
    words.delete();
    for (int k = 0; k < 4; k++) words.push_back($urandom);
    do_start(4, 0, 0, 0);
    session(2, 0, 0, 1'b0);
    n_tests++;
    if (imem_wa.size() - ib != 4) begin
      n_fail++;
      $display("FAIL bp_write_count: got %0d required 4", imem_wa.size() - ib);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (imem_wa[ib+k] != 32'(4 * k) || imem[k] !== words[k]) begin
          n_fail++;
          $display("FAIL bp_word[%0d]: addr=%0d data=%h required %0d %h", k, imem_wa[ib+k],
                   imem[k], 4 * k, words[k]);
        end
      end
    end
  endtask

  task automatic test_run;
    int first_en = -1, last_en = -1, n_en = 0, done_at = -1;
    do_start(0, 0, 10, 0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (enable) begin
        if (first_en < 0) first_en = c;
        last_en = c;
        n_en++;
      end
      if (done && done_at < 0) done_at = c;
    end
    n_tests++;
    if (n_en != 10 || last_en - first_en + 1 != 10 || first_en != 0) begin
      n_fail++;
      $display("FAIL run_enable: cycles=%0d span=%0d first=%0d required 10 10 0", n_en,
               last_en - first_en + 1, first_en);
    end
    n_tests++;
    if (done_at != last_en + 1) begin
      n_fail++;
      $display("FAIL run_done_timing: done at %0d required %0d", done_at, last_en + 1);
    end
  endtask

  task automatic test_dump;
    int rb;
    words = '{32'hA, 32'hB, 32'hC};
    do_start(0, 3, 0, 0);
    session(0, 0, 0, 1'b0);
    rb = ren_a.size();
    words.delete();
    do_start(0, 0, 0, 3);
    session(0, 1, 5, 1'b0);
    n_tests++;
    if (got.size() != 3 || got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
      n_fail++;
      $display("FAIL dump_stream: got %p required A B C", got);
    end
    n_tests++;
    if (ren_a.size() - rb != 3 || ren_a[rb] != 0 || ren_a[rb+1] != 4 || ren_a[rb+2] != 8) begin
      n_fail++;
      $display("FAIL dump_read_addrs: count=%0d required reads at 0 4 8", ren_a.size() - rb);
    end
    n_tests++;
    if (stab_err != 0 || stall_cycles < 5) begin
      n_fail++;
      $display("FAIL dump_hold_stable: unstable=%0d stalls=%0d required 0 and >=5", stab_err,
               stall_cycles);
    end
  endtask

  task automatic test_full_flow;
    int e0 = en_cycles;
    cpu_len = 4;
    cpu_rst = 1'b1;
    @(negedge clk);
    cpu_rst = 1'b0;
    cpu_on = 1'b1;
    words = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820, 32'hAC03_0000, 32'h0};
    do_start(4, 1, 20, 1);
    session(1, 1, 0, 1'b1);
    cpu_on = 1'b0;
    n_tests++;
    if (got.size() != 1 || got[0] !== 32'd12) begin
      n_fail++;
      $display("FAIL full_flow_sum: got %p required 12", got);
    end
    n_tests++;
    if (en_cycles - e0 != 20) begin
      n_fail++;
      $display("FAIL full_flow_run: enable cycles %0d required 20", en_cycles - e0);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      int ni = $urandom_range(0, 6);
      int nd = $urandom_range(0, 6);
      int nr = $urandom_range(0, 5);
      int nu = $urandom_range(0, nd);
      int ib = imem_wa.size();
      int e0 = en_cycles;
      words.delete();
      for (int k = 0; k < ni + nd; k++) words.push_back($urandom);
      do_start(ni, nd, nr, nu);
      session(1, 1, 0, 1'b0);
      n_tests++;
      if (imem_wa.size() - ib != ni || en_cycles - e0 != nr) begin
        n_fail++;
        $display("FAIL rand%0d_counts: writes=%0d enable=%0d required %0d %0d", it,
                 imem_wa.size() - ib, en_cycles - e0, ni, nr);
      end
      for (int k = 0; k < ni; k++) begin
        n_tests++;
        if (imem[k] !== words[k]) begin
          n_fail++;
          $display("FAIL rand%0d_imem[%0d]: got %h required %h", it, k, imem[k], words[k]);
        end
      end
      for (int k = 0; k < nd; k++) begin
        n_tests++;
        if (dmem[k] !== words[ni+k]) begin
          n_fail++;
          $display("FAIL rand%0d_dmem[%0d]: got %h required %h", it, k, dmem[k], words[ni+k]);
        end
      end
      n_tests++;
      if (got.size() != nu || stab_err != 0) begin
        n_fail++;
        $display("FAIL rand%0d_dump_len: got %0d unstable %0d required %0d 0", it, got.size(),
                 stab_err, nu);
      end else begin
        for (int k = 0; k < nu; k++) begin
          n_tests++;
          if (got[k] !== words[ni+k]) begin
            n_fail++;
            $display("FAIL rand%0d_dump[%0d]: got %h required %h", it, k, got[k], words[ni+k]);
          end
        end
      end
    end
  endtask

  task automatic test_tieoffs;
    n_tests++;
    if (tie_err != 0) begin
      n_fail++;
      $display("FAIL port_rules: violating cycles %0d required 0", tie_err);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    test_reset;
    test_load;
    test_backpressure;
    test_run;
    test_dump;
    test_full_flow;
    test_random;
    test_tieoffs;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
